axi2ram_rdata_gen: RTL and testbench
====================================

Name: axi2ram_rdata_gen

Overview:
Read-data side of the AXI-slave-to-SRAM bridge. Pops RAM commands from the command FIFO filled by the address generator and issues single-cycle SRAM reads. Tracks the fixed SRAM read latency and buffers returned words. Drives the AXI R channel (RID/RDATA/RRESP/RLAST) with full RREADY backpressure.

Parameters:
C_ID, 16, AXI ID width
C_RAM_AW, 15, SRAM word-address width
C_RDW, 128, SRAM / RDATA width in bits
C_RAM_RL, 1, SRAM read latency in cycles from ram_rd_en to valid ram_rd_data (legal 1..3)
C_OBUF_DEPTH, 4, output buffer entries (power of 2, >= C_RAM_RL+2)

Ports:
aclk_s  in  1  clock
rst_n  in  1  asynchronous active-low reset
ram_cmd_info  in  C_ID+C_RAM_AW+2  {last, id, addr[C_RAM_AW:0]}, MSB first; addr[C_RAM_AW] is the out-of-range bit
ram_cmd_empty  in  1  command FIFO empty
ram_cmd_pop  out  1  command FIFO pop
ram_rd_en  out  1  SRAM read strobe
ram_rd_addr  out  C_RAM_AW  SRAM word address
ram_rd_data  in  C_RDW  SRAM read data
s_rvalid  out  1  R channel valid
s_rready  in  1  R channel ready
s_rid  out  C_ID  R channel ID
s_rdata  out  C_RDW  R channel data
s_rresp  out  2  R channel response
s_rlast  out  1  R channel last

Behaviour:
- Reset is asynchronous on rst_n, clock is aclk_s. Reset clears the credit counter, latency pipe valids and buffer pointers. All outputs reset to 0, so s_rvalid=0 and ram_cmd_pop=0.
- Credit counter cnt (width clog2(C_OBUF_DEPTH)+1) = reads in the latency pipe + buffered entries.
- Pop rule: ram_cmd_pop = ~ram_cmd_empty & (cnt < C_OBUF_DEPTH).
  - Only registered terms are used; there is no combinational path from s_rready to the pop.
- ram_rd_en = ram_cmd_pop. ram_rd_addr = addr[C_RAM_AW-1:0], driven in the same cycle as the pop.
- cnt update:
  - +1 on pop.
  - -1 on R handshake (s_rvalid & s_rready).
  - Pop and handshake in the same cycle: cnt unchanged.
- Latency pipe: C_RAM_RL stages carrying {valid, id, last, err}. Stage 0 loads on pop.
  - At the last stage, if valid, ram_rd_data is captured together with the sideband into the buffer tail.
  - Buffer overflow is impossible by construction of the credit rule.
- Output buffer: C_OBUF_DEPTH-entry FIFO; R outputs are driven from the head.
  - s_rvalid = buffer not empty.
  - Head outputs stay stable while s_rvalid & ~s_rready (AXI hold rule).
  - Head advances only on handshake.
  - Write and read in the same cycle are both honoured, including when the buffer is empty: the new entry becomes visible next cycle.
- Latency: cmd pop at cycle T gives the earliest s_rvalid at T+C_RAM_RL+1.
- Throughput: with s_rready=1, one beat per cycle sustained indefinitely, provided C_OBUF_DEPTH >= C_RAM_RL+2.
- s_rlast = last bit of the command; s_rid = id of the command.
  - Beats leave in command order; no reordering or interleaving.
- s_rresp = 2'b00 (OKAY) unless the optional feature applies.
- Empty command FIFO: no pop, no read; returning pipe data still drains.
- Reset mid-burst:
  - In-flight and buffered beats are discarded and s_rvalid drops to 0 asynchronously.
  - The command FIFO and the address generator are reset by the same rst_n.

Optional Feature:
Macro AXI2RAM_RD_RANGE_ERR_EN.
- Defined:
  - Command with addr[C_RAM_AW]=1: the pipe err bit is set and ram_rd_en is suppressed for that pop; pop, credit and timing are unchanged.
  - The beat returns s_rresp=2'b10 (SLVERR) and s_rdata=0.
- Undefined: addr[C_RAM_AW] is ignored; the read always goes to the SRAM and s_rresp is always 2'b00.

Test Plan:
- Single beat: cmd {last=1, id=0x5, addr=0x10}, RL=1, s_rready=1 -> ram_rd_en with addr 0x10 at T; s_rvalid, s_rid=0x5, s_rlast=1, RDATA=mem[0x10] at T+2; pop stays low afterward.
- Burst: 8 cmds id=0x3, addr 0x20..0x27, last on the 8th, s_rready=1 -> 8 consecutive beats with data mem[0x20..0x27], rlast only on beat 8, no bubbles.
- Backpressure: s_rready=0 with 10 cmds queued -> exactly 4 pops, then ram_cmd_pop=0 and s_rvalid held with stable head. Raise s_rready -> remaining 6 drain in order, no loss or duplication.
- Simultaneous pop and handshake at cnt=4 -> no pop that cycle (cnt<4 false); pop resumes the next cycle with cnt=3; final beat count equals command count.
- Reset mid-burst: assert rst_n=0 after beat 3 of 8 -> s_rvalid=0 immediately. After release with an empty cmd FIFO -> no beats, cnt=0.
- With AXI2RAM_RD_RANGE_ERR_EN: cmd addr bit C_RAM_AW set -> no ram_rd_en, beat returns rresp=2'b10, rdata=0, correct id and last. Without the macro -> rresp=2'b00 and data read from SRAM.

Source files
------------

// File: rtl/axi2ram_rdata_gen.sv
// R-channel generator: pops RAM commands, issues SRAM reads, buffers returned words for AXI R (option: AXI2RAM_RD_RANGE_ERR_EN).
// Latency: pop at T gives earliest s_rvalid at T+C_RAM_RL+1; one beat per cycle sustained with s_rready=1.
// Backpressure: credit counter stops pops once pipe+buffer hold C_OBUF_DEPTH beats; s_rready never feeds the pop.
module axi2ram_rdata_gen #(
  parameter int C_ID         = 16,
  parameter int C_RAM_AW     = 15,
  parameter int C_RDW        = 128,
  parameter int C_RAM_RL     = 1,
  parameter int C_OBUF_DEPTH = 4
) (
  input  logic                       aclk_s,
  input  logic                       rst_n,
  input  logic [C_ID+C_RAM_AW+1:0]   ram_cmd_info,
  input  logic                       ram_cmd_empty,
  output logic                       ram_cmd_pop,
  output logic                       ram_rd_en,
  output logic [C_RAM_AW-1:0]        ram_rd_addr,
  input  logic [C_RDW-1:0]           ram_rd_data,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [C_ID-1:0]            s_rid,
  output logic [C_RDW-1:0]           s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rlast
);

  localparam int PW = $clog2(C_OBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(C_OBUF_DEPTH);

  typedef struct packed {
    logic            vld;
    logic [C_ID-1:0] id;
    logic            last;
    logic            err;
  } pipe_t;

  typedef struct packed {
    logic [C_ID-1:0]  id;
    logic             last;
    logic [1:0]       resp;
    logic [C_RDW-1:0] data;
  } ent_t;

  logic                cmd_last;
  logic [C_ID-1:0]     cmd_id;
  logic                cmd_oor;
  logic [C_RAM_AW-1:0] cmd_addr;
  logic                cmd_err;

  assign {cmd_last, cmd_id, cmd_oor, cmd_addr} = ram_cmd_info;

`ifdef AXI2RAM_RD_RANGE_ERR_EN
  assign cmd_err = cmd_oor;
`else
  logic unused_oor;
  assign cmd_err    = 1'b0;
  assign unused_oor = cmd_oor;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  pipe_t         pipe_q [C_RAM_RL];
  pipe_t         pipe_d [C_RAM_RL];
  ent_t          buf_q  [C_OBUF_DEPTH];
  ent_t          buf_d  [C_OBUF_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          pop, hs;
  ent_t          head, wr_ent;

  // Credit counts beats in the pipe plus beats buffered, so the tail can never overflow.
  assign pop         = ~ram_cmd_empty & (cnt_q < DEPTH);
  assign ram_cmd_pop = pop;
  assign ram_rd_en   = pop & ~cmd_err;
  assign ram_rd_addr = ram_rd_en ? cmd_addr : '0;

  assign s_rvalid = (wr_ptr_q != rd_ptr_q);
  assign hs       = s_rvalid & s_rready;
  assign head     = buf_q[rd_ptr_q[PW-1:0]];
  assign s_rid    = s_rvalid ? head.id   : '0;
  assign s_rdata  = s_rvalid ? head.data : '0;
  assign s_rresp  = s_rvalid ? head.resp : 2'b00;
  assign s_rlast  = s_rvalid ? head.last : 1'b0;

  always_comb begin
    cnt_d = cnt_q;
    case ({pop, hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    pipe_d[0] = {pop, cmd_id, cmd_last, cmd_err};
    for (int i = 1; i < C_RAM_RL; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    // Range errors return a zeroed SLVERR beat instead of whatever sits on the SRAM bus.
    wr_ent.id   = pipe_q[C_RAM_RL-1].id;
    wr_ent.last = pipe_q[C_RAM_RL-1].last;
    wr_ent.resp = pipe_q[C_RAM_RL-1].err ? 2'b10 : 2'b00;
    wr_ent.data = pipe_q[C_RAM_RL-1].err ? '0 : ram_rd_data;

    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pipe_q[C_RAM_RL-1].vld) begin
      buf_d[wr_ptr_q[PW-1:0]] = wr_ent;
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (hs) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge aclk_s or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pipe_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage only; validity comes from the reset pointers.
  always_ff @(posedge aclk_s) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_axi2ram_rdata_gen.sv
// Directed bench for axi2ram_rdata_gen: command FIFO and 1-cycle SRAM models, vector table plus corner sequences.
module tb_axi2ram_rdata_gen;

  logic          aclk_s = 1'b0;
  logic          rst_n  = 1'b0;
  logic [32:0]   ram_cmd_info;
  logic          ram_cmd_empty;
  logic          ram_cmd_pop;
  logic          ram_rd_en;
  logic [14:0]   ram_rd_addr;
  logic [127:0]  ram_rd_data = '0;
  logic          s_rvalid;
  logic          s_rready = 1'b1;
  logic [15:0]   s_rid;
  logic [127:0]  s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;

  int checks = 0;
  int errors = 0;

  always #5 aclk_s = ~aclk_s;

  axi2ram_rdata_gen dut (
    .aclk_s        (aclk_s),
    .rst_n         (rst_n),
    .ram_cmd_info  (ram_cmd_info),
    .ram_cmd_empty (ram_cmd_empty),
    .ram_cmd_pop   (ram_cmd_pop),
    .ram_rd_en     (ram_rd_en),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .s_rvalid      (s_rvalid),
    .s_rready      (s_rready),
    .s_rid         (s_rid),
    .s_rdata       (s_rdata),
    .s_rresp       (s_rresp),
    .s_rlast       (s_rlast)
  );

  function automatic logic [127:0] memf(input logic [14:0] a);
    return {4{{17'h0ACE5, a}}};
  endfunction

  // Command FIFO model, reset by the same rst_n.
  logic [32:0] cmd_mem [64];
  int          cmd_wr = 0;
  int          cmd_rd = 0;
  assign ram_cmd_empty = (cmd_rd == cmd_wr);
  assign ram_cmd_info  = cmd_mem[cmd_rd[5:0]];

  always @(posedge aclk_s or negedge rst_n) begin
    if (!rst_n)           cmd_rd <= cmd_wr;
    else if (ram_cmd_pop) cmd_rd <= cmd_rd + 1;
  end

  always @(posedge aclk_s) begin
    if (ram_rd_en) ram_rd_data <= memf(ram_rd_addr);
  end

  // Monitor: counts pops/reads and records every R handshake.
  int           cyc = 0;
  int           pop_n = 0;
  int           rden_n = 0;
  int           obs_n = 0;
  logic [15:0]  obs_id   [64];
  logic         obs_last [64];
  logic [1:0]   obs_resp [64];
  logic [127:0] obs_data [64];
  int           obs_cyc  [64];

  always @(posedge aclk_s) cyc <= cyc + 1;

  always @(negedge aclk_s) begin
    if (rst_n) begin
      if (ram_cmd_pop) pop_n <= pop_n + 1;
      if (ram_rd_en)   rden_n <= rden_n + 1;
      if (s_rvalid && s_rready && obs_n < 64) begin
        obs_id[obs_n]   <= s_rid;
        obs_last[obs_n] <= s_rlast;
        obs_resp[obs_n] <= s_rresp;
        obs_data[obs_n] <= s_rdata;
        obs_cyc[obs_n]  <= cyc;
        obs_n           <= obs_n + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic last, input logic [15:0] id, input logic [15:0] addr);
    cmd_mem[cmd_wr[5:0]] = {last, id, addr};
    cmd_wr = cmd_wr + 1;
  endtask

  task automatic wait_beats(input int target, input string name);
    int k = 0;
    while (obs_n < target && k < 300) begin
      @(posedge aclk_s);
      k++;
    end
    chk(name, 128'(obs_n), 128'(target));
  endtask

  typedef struct {
    logic         last;
    logic [15:0]  id;
    logic [15:0]  addr;
    logic [15:0]  exp_id;
    logic         exp_last;
    logic [1:0]   exp_resp;
    logic [127:0] exp_data;
  } vec_t;

  vec_t tbl [11];

  task automatic set_vec(input int i, input logic last, input logic [15:0] id, input logic [15:0] addr,
                         input logic [1:0] resp, input logic [127:0] data);
    tbl[i].last     = last;
    tbl[i].id       = id;
    tbl[i].addr     = addr;
    tbl[i].exp_id   = id;
    tbl[i].exp_last = last;
    tbl[i].exp_resp = resp;
    tbl[i].exp_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, pb, rb, bub, exp_rden;

    for (int i = 0; i < 64; i++) cmd_mem[i] = '0;
    for (int i = 0; i < 8; i++)
      set_vec(i, (i == 7), 16'h0003, 16'h0020 + 16'(i), 2'b00, memf(15'h0020 + 15'(i)));
    set_vec(8, 1'b1, 16'hABCD, 16'h7FFF, 2'b00, memf(15'h7FFF));
`ifdef AXI2RAM_RD_RANGE_ERR_EN
    set_vec(9, 1'b1, 16'h0001, 16'h8005, 2'b10, '0);
    exp_rden = 10;
`else
    set_vec(9, 1'b1, 16'h0001, 16'h8005, 2'b00, memf(15'h0005));
    exp_rden = 11;
`endif
    set_vec(10, 1'b0, 16'hFFFF, 16'h0000, 2'b00, memf(15'h0000));

    // Reset state
    #3;
    chk("rst_rvalid", 128'(s_rvalid), 128'(0));
    chk("rst_pop",    128'(ram_cmd_pop), 128'(0));
    chk("rst_rd_en",  128'(ram_rd_en), 128'(0));
    chk("rst_rid",    128'(s_rid), 128'(0));
    chk("rst_rlast",  128'(s_rlast), 128'(0));
    repeat (2) @(posedge aclk_s);
    #2 rst_n = 1'b1;

    // Single beat: pop at T, beat visible at T+2 for RL=1
    @(posedge aclk_s); #1;
    push(1'b1, 16'h0005, 16'h0010);
    @(negedge aclk_s);
    chk("single_pop",   128'(ram_cmd_pop), 128'(1));
    chk("single_rd_en", 128'(ram_rd_en), 128'(1));
    chk("single_addr",  128'(ram_rd_addr), 128'(15'h0010));
    @(negedge aclk_s);
    chk("single_t1_rvalid", 128'(s_rvalid), 128'(0));
    @(negedge aclk_s);
    chk("single_t2_rvalid", 128'(s_rvalid), 128'(1));
    chk("single_rid",   128'(s_rid), 128'(16'h0005));
    chk("single_rlast", 128'(s_rlast), 128'(1));
    chk("single_rdata", s_rdata, memf(15'h0010));
    chk("single_rresp", 128'(s_rresp), 128'(0));
    @(negedge aclk_s);
    chk("single_after_rvalid", 128'(s_rvalid), 128'(0));
    chk("single_after_pop",    128'(ram_cmd_pop), 128'(0));

    // Vector table: burst, top address, out-of-range address, max id
    @(posedge aclk_s); #1;
    base = obs_n; pb = pop_n; rb = rden_n;
    for (int i = 0; i < 11; i++) push(tbl[i].last, tbl[i].id, tbl[i].addr);
    wait_beats(base + 11, "tbl_beat_count");
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tbl%0d_rid", i),   128'(obs_id[base+i]),   128'(tbl[i].exp_id));
      chk($sformatf("tbl%0d_rlast", i), 128'(obs_last[base+i]), 128'(tbl[i].exp_last));
      chk($sformatf("tbl%0d_rresp", i), 128'(obs_resp[base+i]), 128'(tbl[i].exp_resp));
      chk($sformatf("tbl%0d_rdata", i), obs_data[base+i],       tbl[i].exp_data);
    end
    bub = 0;
    for (int i = 1; i < 11; i++)
      if (obs_cyc[base+i] != obs_cyc[base+i-1] + 1) bub++;
    chk("tbl_no_bubbles", 128'(bub), 128'(0));
    @(posedge aclk_s); #1;
    chk("tbl_pops",  128'(pop_n - pb), 128'(11));
    chk("tbl_rd_en", 128'(rden_n - rb), 128'(exp_rden));

    // Backpressure: 10 queued, only 4 credits
    s_rready = 1'b0;
    base = obs_n; pb = pop_n;
    for (int i = 0; i < 10; i++) push((i == 9), 16'h0007, 16'h0040 + 16'(i));
    repeat (10) @(posedge aclk_s);
    #1;
    chk("bp_pop_count", 128'(pop_n - pb), 128'(4));
    @(negedge aclk_s);
    chk("bp_pop_stalled", 128'(ram_cmd_pop), 128'(0));
    chk("bp_rvalid",      128'(s_rvalid), 128'(1));
    chk("bp_head_rid",    128'(s_rid), 128'(16'h0007));
    chk("bp_head_rdata",  s_rdata, memf(15'h0040));
    repeat (3) @(negedge aclk_s);
    chk("bp_hold_rdata",  s_rdata, memf(15'h0040));
    chk("bp_hold_rlast",  128'(s_rlast), 128'(0));
    @(posedge aclk_s); #1;
    s_rready = 1'b1;
    @(negedge aclk_s);
    chk("bp_pop_at_cnt4_with_hs", 128'(ram_cmd_pop), 128'(0));
    @(negedge aclk_s);
    chk("bp_pop_resumes", 128'(ram_cmd_pop), 128'(1));
    wait_beats(base + 10, "bp_beat_count");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d_rdata", i), obs_data[base+i], memf(15'h0040 + 15'(i)));
      chk($sformatf("bp%0d_rlast", i), 128'(obs_last[base+i]), 128'(i == 9));
    end
    @(posedge aclk_s); #1;
    chk("bp_total_pops", 128'(pop_n - pb), 128'(10));

    // Reset mid-burst after beat 3 of 8
    base = obs_n;
    for (int i = 0; i < 8; i++) push((i == 7), 16'h0009, 16'h0060 + 16'(i));
    wait_beats(base + 3, "rst_burst_three_beats");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 128'(s_rvalid), 128'(0));
    chk("rst_mid_pop",    128'(ram_cmd_pop), 128'(0));
    repeat (2) @(posedge aclk_s);
    #2 rst_n = 1'b1;
    pb = pop_n;
    repeat (10) @(posedge aclk_s);
    #1;
    chk("rst_after_beats",  128'(obs_n), 128'(base + 3));
    chk("rst_after_pops",   128'(pop_n - pb), 128'(0));
    chk("rst_after_rvalid", 128'(s_rvalid), 128'(0));

    // Credits restart from zero: exactly 4 pops with 6 queued and no ready
    s_rready = 1'b0;
    base = obs_n; pb = pop_n;
    for (int i = 0; i < 6; i++) push((i == 5), 16'h000C, 16'h0070 + 16'(i));
    repeat (8) @(posedge aclk_s);
    #1;
    chk("rst_credit_pops", 128'(pop_n - pb), 128'(4));
    s_rready = 1'b1;
    wait_beats(base + 6, "rst_drain_count");
    for (int i = 0; i < 6; i++)
      chk($sformatf("rst_drain%0d_rdata", i), obs_data[base+i], memf(15'h0070 + 15'(i)));
    chk("rst_drain_last_rid", 128'(obs_id[base+5]), 128'(16'h000C));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
